custom_uart_top: RTL and testbench
==================================

// Module: custom_uart_top
// PURPOSE
//  Full-duplex 8N1 UART (8 data bits, no parity, 1 stop bit, LSB first) with a byte write
//  port for TX and a byte/strobe read port for RX. Sits between the system fabric and the pins.
//  RX flags framing and false-start errors and exports debug probes for bring-up on a scope.
// PARAMETERS
//  SYSTEM_CLOCK   100000000  system_clk frequency, Hz
//  UART_BAUDRATE  115200     line rate, bits/s; BIT_CYC = SYSTEM_CLOCK/UART_BAUDRATE (integer, truncated; 868 at 99999001/115200)
// PORTS
//  system_clk       in   1  single clock; all logic on rising edge
//  reset            in   1  reset is synchronous and active-high
//  din              in   8  TX byte, sampled on accepted wr_en
//  wr_en            in   1  TX write strobe (one cycle)
//  tx               out  1  serial out, idle high
//  tx_busy          out  1  high while a TX frame is in progress
//  rx               in   1  serial in, asynchronous, idle high
//  rx_complete      out  1  one-cycle pulse: valid byte on dout
//  dout             out  8  last good RX byte, held until next good frame
//  rx_error_bit     out  2  [0]=framing error (stop bit low), [1]=false start
//  deb_rx           out  1  synchronized rx
//  deb_rx_complete  out  1  copy of rx_complete
//  deb_rx_clk       out  1  toggles at every RX mid-bit sample instant
//  debuging_high    out  1  constant 1 (probe-alive indicator)
// BEHAVIOUR
//  Reset: tx=1, tx_busy=0, rx_complete=0, dout=0, rx_error_bit=0, deb_rx=1, deb_rx_complete=0,
//   deb_rx_clk=0, debuging_high=1; both FSMs to IDLE, counters 0. Reset mid-frame aborts the frame.
//  TX FSM IDLE->START->DATA(8)->STOP->IDLE, each state BIT_CYC cycles.
//   - wr_en while IDLE: latch din; tx_busy=1 next cycle; tx=0 (start) next cycle.
//   - Data bits din[0]..din[7]; stop bit tx=1; tx_busy drops after the full stop bit.
//   - wr_en while tx_busy is ignored (no queue). Back-to-back: wr_en on the cycle tx_busy
//     falls starts the next frame.
//  RX: rx through 2-FF synchronizer (deb_rx = output of 2nd FF).
//   FSM IDLE->START->DATA(8)->STOP->IDLE (plus WAIT_IDLE after framing error).
//   - IDLE: falling edge (1->0) of synced rx -> START, bit counter cleared.
//   - START: sample at BIT_CYC/2; if rx=1 -> rx_error_bit[1]=1, back to IDLE; else DATA.
//   - DATA: sample every BIT_CYC from start centre, shift in LSB first (8 samples).
//   - STOP: sample at stop centre. rx=1 -> dout<=byte, rx_complete pulse 1 cycle,
//     rx_error_bit<=2'b00, IDLE. rx=0 -> rx_error_bit[0]=1, dout unchanged, no pulse,
//     WAIT_IDLE until synced rx=1 (break/stuck-low does not retrigger), then IDLE.
//   - rx_error_bit sticky until next good frame or reset.
//   - rx_complete occurs ~9.5 bit times (+2 sync cycles) after start falling edge.
//   - deb_rx_clk toggles on each of the 10 sample instants (start, 8 data, stop).
//  RX and TX fully independent; simultaneous operation allowed (loopback tx->rx works).
// TESTING (SYSTEM_CLOCK=99999001, UART_BAUDRATE=115200, 10 ns clock, bit time 8680 ns)
//  1. Reset pulse -> all outputs at reset values, tx=1, debuging_high=1.
//  2. RX frame 0xA5, good stop -> one rx_complete pulse, dout=8'hA5, rx_error_bit=00,
//     deb_rx_clk 10 toggles.
//  3. RX frame 0x5A with stop bit 0 -> no rx_complete, dout stays 8'hA5, rx_error_bit=01;
//     rx returns high -> idle; next good 0x3C -> dout=3C, rx_error_bit=00.
//  4. 2000 ns low glitch on rx -> rx_error_bit=10, no rx_complete, dout unchanged.
//  5. wr_en with din=8'h55 -> tx_busy 10 bit times, tx = 0,1,0,1,0,1,0,1,0,1;
//     second wr_en mid-frame ignored.
//  6. tx looped to rx, send 0x00 and 0xFF -> rx_complete with dout=00 then FF.

Source files
------------

// File: rtl/custom_uart_top.sv
// Full-duplex 8N1 UART: byte write port for TX, byte/strobe read port for RX,
// with RX framing/false-start flags and scope debug probes.
`timescale 1ns/1ps
module custom_uart_top #(
  parameter int unsigned SYSTEM_CLOCK  = 100000000,
  parameter int unsigned UART_BAUDRATE = 115200
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rx_complete,
  output logic [7:0] dout,
  output logic [1:0] rx_error_bit,
  output logic       deb_rx,
  output logic       deb_rx_complete,
  output logic       deb_rx_clk,
  output logic       debuging_high
);

  localparam int unsigned BIT_CYC  = SYSTEM_CLOCK / UART_BAUDRATE;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_busy_q, tx_busy_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [7:0]       dout_q, dout_d;
  logic             rx_complete_q, rx_complete_d;
  logic [1:0]       rx_err_q, rx_err_d;
  logic             deb_clk_q, deb_clk_d;

  // TX next-state: each frame state lasts BIT_CYC cycles
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    if (tx_state_q == TX_IDLE) begin
      tx_cnt_d = '0;
      if (wr_en) begin
        tx_shift_d = din;
        tx_state_d = TX_START;
        tx_d       = 1'b0;
        tx_busy_d  = 1'b1;
      end
    end else if (tx_cnt_q != BIT_LAST) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end
        TX_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
        default: begin
          tx_state_d = TX_IDLE;
          tx_busy_d  = 1'b0;
        end
      endcase
    end
  end

  // RX next-state: start centre at HALF_CYC, then every BIT_CYC
  always_comb begin
    rx_meta_d     = rx;
    rx_sync_d     = rx_meta_q;
    rx_prev_d     = rx_sync_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q + CNT_W'(1);
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    dout_d        = dout_q;
    rx_complete_d = 1'b0;
    rx_err_d      = rx_err_q;
    deb_clk_d     = deb_clk_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_bit_d   = 3'd0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d  = '0;
          deb_clk_d = ~deb_clk_q;
          if (rx_sync_q) begin
            rx_err_d   = rx_err_q | 2'b10;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          deb_clk_d  = ~deb_clk_q;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d  = '0;
          deb_clk_d = ~deb_clk_q;
          if (rx_sync_q) begin
            dout_d        = rx_shift_q;
            rx_complete_d = 1'b1;
            rx_err_d      = 2'b00;
            rx_state_d    = RX_IDLE;
          end else begin
            rx_err_d   = rx_err_q | 2'b01;
            rx_state_d = RX_WAIT_IDLE;
          end
        end
      end
      default: begin
        // a held-low line must return high before a new start is accepted
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= 3'd0;
      tx_shift_q    <= 8'd0;
      tx_q          <= 1'b1;
      tx_busy_q     <= 1'b0;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_shift_q    <= 8'd0;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      dout_q        <= 8'd0;
      rx_complete_q <= 1'b0;
      rx_err_q      <= 2'b00;
      deb_clk_q     <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_q          <= tx_d;
      tx_busy_q     <= tx_busy_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      rx_prev_q     <= rx_prev_d;
      dout_q        <= dout_d;
      rx_complete_q <= rx_complete_d;
      rx_err_q      <= rx_err_d;
      deb_clk_q     <= deb_clk_d;
    end
  end

  assign tx              = tx_q;
  assign tx_busy         = tx_busy_q;
  assign rx_complete     = rx_complete_q;
  assign dout            = dout_q;
  assign rx_error_bit    = rx_err_q;
  assign deb_rx          = rx_sync_q;
  assign deb_rx_complete = rx_complete_q;
  assign deb_rx_clk      = deb_clk_q;
  assign debuging_high   = 1'b1;

endmodule

// File: tb/tb_custom_uart_top.sv
// Directed bench for custom_uart_top: RX frames/errors, TX waveform, loopback,
// with an RX byte scoreboard checked on every rx_complete pulse.
`timescale 1ns/1ps
module tb_custom_uart_top;

  localparam int BIT_CYC = 868;
  localparam int HALF    = 434;
  localparam int BIT_NS  = 8680;
  localparam int LIMIT   = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'd0;
  logic       wr_en = 1'b0;
  logic       tx, tx_busy, rx_complete, deb_rx, deb_rx_complete, deb_rx_clk, debuging_high;
  logic [7:0] dout;
  logic [1:0] rx_error_bit;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_in;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int toggles = 0;
  int busy_cyc = 0;
  logic deb_last = 1'b0;
  logic [7:0] sb[$];

  assign rx_in = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  custom_uart_top #(.SYSTEM_CLOCK(99999001), .UART_BAUDRATE(115200)) dut (
    .system_clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .tx(tx), .tx_busy(tx_busy),
    .rx(rx_in), .rx_complete(rx_complete), .dout(dout), .rx_error_bit(rx_error_bit),
    .deb_rx(deb_rx), .deb_rx_complete(deb_rx_complete), .deb_rx_clk(deb_rx_clk),
    .debuging_high(debuging_high)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard pop on every received byte, plus probe counters
  always @(negedge clk) begin
    if (deb_rx_clk !== deb_last) toggles++;
    deb_last = deb_rx_clk;
    if (tx_busy) busy_cyc++;
    if (rx_complete === 1'b1) begin
      pulses++;
      check("deb_rx_complete", 32'(deb_rx_complete), 32'd1);
      if (sb.size() == 0) check("rx_sb_nonempty", 32'(sb.size()), 32'd1);
      else check("rx_dout", 32'(dout), 32'(sb.pop_front()));
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(BIT_NS);
    end
    rx_drv = stop_bit;
    #(BIT_NS);
    rx_drv = 1'b1;
    #(BIT_NS);
  endtask

  task automatic write_tx(input logic [7:0] b);
    din   = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < LIMIT), 32'd1);
  endtask

  initial begin
    int p0, t0;
    logic [9:0] exp_tx;

    // 1. reset values
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_complete", 32'(rx_complete), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_err", 32'(rx_error_bit), 32'd0);
    check("rst_deb_rx", 32'(deb_rx), 32'd1);
    check("rst_deb_rx_complete", 32'(deb_rx_complete), 32'd0);
    check("rst_deb_rx_clk", 32'(deb_rx_clk), 32'd0);
    check("rst_debuging_high", 32'(debuging_high), 32'd1);
    repeat (10) @(negedge clk);

    // 2. good frame 0xA5
    p0 = pulses; t0 = toggles;
    sb.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    check("a5_pulses", 32'(pulses - p0), 32'd1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_err", 32'(rx_error_bit), 32'd0);
    check("a5_deb_clk_toggles", 32'(toggles - t0), 32'd10);
    check("a5_sb_empty", 32'(sb.size()), 32'd0);

    // 3. framing error then recovery
    p0 = pulses;
    send_rx(8'h5A, 1'b0);
    check("fe_pulses", 32'(pulses - p0), 32'd0);
    check("fe_dout_held", 32'(dout), 32'hA5);
    check("fe_err", 32'(rx_error_bit), 32'd1);
    sb.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    check("3c_pulses", 32'(pulses - p0), 32'd1);
    check("3c_dout", 32'(dout), 32'h3C);
    check("3c_err", 32'(rx_error_bit), 32'd0);

    // 4. 2000 ns glitch -> false start
    p0 = pulses;
    rx_drv = 1'b0;
    #2000;
    rx_drv = 1'b1;
    #(2 * BIT_NS);
    check("gl_err", 32'(rx_error_bit), 32'd2);
    check("gl_pulses", 32'(pulses - p0), 32'd0);
    check("gl_dout_held", 32'(dout), 32'h3C);

    // 5. TX 0x55 waveform at bit centres, mid-frame write ignored
    @(negedge clk);
    busy_cyc = 0;
    exp_tx = {1'b1, 8'h55, 1'b0};
    write_tx(8'h55);
    check("tx_busy_rise", 32'(tx_busy), 32'd1);
    check("tx_start_edge", 32'(tx), 32'd0);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), 32'(tx), 32'(exp_tx[k]));
      check($sformatf("tx_busy_bit%0d", k), 32'(tx_busy), 32'd1);
      if (k == 4) begin
        write_tx(8'hFF);
        repeat (BIT_CYC - 1) @(negedge clk);
      end else begin
        repeat (BIT_CYC) @(negedge clk);
      end
    end
    check("tx_busy_fall", 32'(tx_busy), 32'd0);
    check("tx_idle_level", 32'(tx), 32'd1);
    check("tx_busy_cycles", 32'(busy_cyc), 32'(10 * BIT_CYC));
    repeat (BIT_CYC) @(negedge clk);
    check("tx_ignored_write", 32'(tx_busy), 32'd0);

    // 6. loopback 0x00 then 0xFF back-to-back
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    p0 = pulses;
    sb.push_back(8'h00);
    write_tx(8'h00);
    wait_tx_idle("lb_wait0");
    sb.push_back(8'hFF);
    write_tx(8'hFF);
    check("lb_back_to_back", 32'(tx_busy), 32'd1);
    wait_tx_idle("lb_wait1");
    #(2 * BIT_NS);
    check("lb_pulses", 32'(pulses - p0), 32'd2);
    check("lb_dout", 32'(dout), 32'hFF);
    check("lb_sb_empty", 32'(sb.size()), 32'd0);
    check("lb_err", 32'(rx_error_bit), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
